// File: rtl/hazard_info_pipe_pkg.sv
// ============================================================================
// Module : hazard_info_pipe_pkg
// Brief  : Shared pipeline definitions: result-source codes, MIPS opcode and
//          funct constants, and the destination/result classifier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_info_pipe_pkg;

    // Result-source codes carried alongside each destination register
    localparam logic [1:0] RES_NW  = 2'b00;
    localparam logic [1:0] RES_ALU = 2'b01;
    localparam logic [1:0] RES_DM  = 2'b10;
    localparam logic [1:0] RES_PC  = 2'b11;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Which instruction field (if any) names the written register
    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_RT   = 2'd1,
        DST_RD   = 2'd2,
        DST_RA   = 2'd3
    } dst_sel_t;

    typedef struct packed {
        dst_sel_t   dst;
        logic [1:0] res;
    } decode_ctl_t;

    function automatic decode_ctl_t classify(input logic [5:0] op,
                                             input logic [5:0] funct);
        decode_ctl_t ctl;
        ctl.dst = DST_NONE;
        ctl.res = RES_NW;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_AND: begin
                        ctl.dst = DST_RD;
                        ctl.res = RES_ALU;
                    end
                    FN_JR: begin
                        ctl.dst = DST_NONE;
                        ctl.res = RES_NW;
                    end
                    default: begin
                        ctl.dst = DST_NONE;
                        ctl.res = RES_NW;
                    end
                endcase
            end
            OP_ORI, OP_ADDI, OP_LUI: begin
                ctl.dst = DST_RT;
                ctl.res = RES_ALU;
            end
            OP_LW: begin
                ctl.dst = DST_RT;
                ctl.res = RES_DM;
            end
            OP_JAL: begin
                ctl.dst = DST_RA;
                ctl.res = RES_PC;
            end
            OP_BEQ, OP_J, OP_SW: begin
                ctl.dst = DST_NONE;
                ctl.res = RES_NW;
            end
            default: begin
                ctl.dst = DST_NONE;
                ctl.res = RES_NW;
            end
        endcase
        return ctl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_info_pipe_decode.sv
// ============================================================================
// Module : hazard_info_decode
// Brief  : Combinational D-stage decode of source/destination registers and
//          result-source code.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_info_decode
    import hazard_info_pipe_pkg::*;
#(
    parameter int RES_W = 2
) (
    input  logic [31:0]      instr,
    output logic [4:0]       a1,
    output logic [4:0]       a2,
    output logic [4:0]       a3,
    output logic [RES_W-1:0] res
);

    decode_ctl_t ctl;
    logic        unused_shamt;

    assign unused_shamt = ^instr[10:6];

    assign a1 = instr[25:21];
    assign a2 = instr[20:16];

    always_comb begin
        ctl = classify(instr[31:26], instr[5:0]);
        case (ctl.dst)
            DST_RT:  a3 = instr[20:16];
            DST_RD:  a3 = instr[15:11];
            DST_RA:  a3 = REG_RA;
            default: a3 = REG_ZERO;
        endcase
        // A write to $0 is architecturally a no-write; never report a source
        res = (a3 == REG_ZERO) ? RES_W'(RES_NW) : RES_W'(ctl.res);
    end

endmodule

`default_nettype wire

// File: rtl/hazard_info_pipe.sv
// ============================================================================
// Module : hazard_info_pipe
// Brief  : D/E/M/W pipeline of register-address and result-source info used
//          for forwarding and stall decisions, with bubble/stall control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_info_pipe
    import hazard_info_pipe_pkg::*;
#(
    parameter int RES_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_d,
    input  logic             stall,
    input  logic             flush_d,
    output logic [4:0]       A1D,
    output logic [4:0]       A2D,
    output logic [4:0]       A1E,
    output logic [4:0]       A2E,
    output logic [4:0]       A3E,
    output logic [4:0]       A3M,
    output logic [4:0]       A3W,
    output logic [RES_W-1:0] res_E,
    output logic [RES_W-1:0] res_M,
    output logic [RES_W-1:0] res_W,
    output logic             en_pc,
    output logic             en_d,
    output logic             clr_e,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [4:0]       a3_d;
    logic [RES_W-1:0] res_d;
    logic             bubble_e;

    hazard_info_decode #(
        .RES_W (RES_W)
    ) u_decode (
        .instr (instr_d),
        .a1    (A1D),
        .a2    (A2D),
        .a3    (a3_d),
        .res   (res_d)
    );

    // Stall wins over flush; either way E receives a bubble
    assign bubble_e = stall | flush_d;

    assign en_pc = ~stall;
    assign en_d  = ~stall;
    assign clr_e = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A1E   <= REG_ZERO;
            A2E   <= REG_ZERO;
            A3E   <= REG_ZERO;
            res_E <= RES_W'(RES_NW);
        end else if (bubble_e) begin
            A1E   <= REG_ZERO;
            A2E   <= REG_ZERO;
            A3E   <= REG_ZERO;
            res_E <= RES_W'(RES_NW);
        end else begin
            A1E   <= A1D;
            A2E   <= A2D;
            A3E   <= a3_d;
            res_E <= res_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A3M   <= REG_ZERO;
            res_M <= RES_W'(RES_NW);
            A3W   <= REG_ZERO;
            res_W <= RES_W'(RES_NW);
        end else begin
            A3M   <= A3E;
            res_M <= res_E;
            A3W   <= A3M;
            res_W <= res_M;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_info_pipe.sv
// ============================================================================
// Module : tb_hazard_info_pipe
// Brief  : Self-checking bench for hazard_info_pipe against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_info_pipe;

    localparam int RES_W = 2;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       instr_d;
    logic              stall;
    logic              flush_d;
    logic [4:0]        A1D, A2D, A1E, A2E, A3E, A3M, A3W;
    logic [RES_W-1:0]  res_E, res_M, res_W;
    logic              en_pc, en_d, clr_e;
    logic [CNT_W-1:0]  stall_cnt;

    hazard_info_pipe #(
        .RES_W (RES_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr_d   (instr_d),
        .stall     (stall),
        .flush_d   (flush_d),
        .A1D       (A1D),
        .A2D       (A2D),
        .A1E       (A1E),
        .A2E       (A2E),
        .A3E       (A3E),
        .A3M       (A3M),
        .A3W       (A3W),
        .res_E     (res_E),
        .res_M     (res_M),
        .res_W     (res_W),
        .en_pc     (en_pc),
        .en_d      (en_d),
        .clr_e     (clr_e),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: history of what entered E; E/M/W are the last three entries
    typedef struct {
        int a1;
        int a2;
        int a3;
        int res;
    } ent_t;

    ent_t hist[$];
    int   ref_cnt;

    function automatic ent_t bubble();
        ent_t e;
        e.a1 = 0; e.a2 = 0; e.a3 = 0; e.res = 0;
        return e;
    endfunction

    function automatic ent_t ref_decode(input logic [31:0] ins);
        ent_t e;
        int op, fn;
        op   = int'(ins[31:26]);
        fn   = int'(ins[5:0]);
        e.a1 = int'(ins[25:21]);
        e.a2 = int'(ins[20:16]);
        e.a3 = 0;
        e.res = 0;
        if (op == 0) begin
            if (fn == 'h21 || fn == 'h23 || fn == 'h24) begin
                e.a3 = int'(ins[15:11]); e.res = 1;
            end
        end else if (op == 'h0d || op == 'h08 || op == 'h0f) begin
            e.a3 = int'(ins[20:16]); e.res = 1;
        end else if (op == 'h23) begin
            e.a3 = int'(ins[20:16]); e.res = 2;
        end else if (op == 'h03) begin
            e.a3 = 31; e.res = 3;
        end
        if (e.a3 == 0) e.res = 0;
        return e;
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (3) hist.push_back(bubble());
        ref_cnt = 0;
    endtask

    task automatic model_edge(input ent_t nxt, input logic st);
        hist.push_back(nxt);
        void'(hist.pop_front());
        if (st && ref_cnt < CNT_MAX) ref_cnt++;
    endtask

    task automatic check_pipe(input string tag);
        check({tag, ".A1E"},   32'(A1E),       hist[2].a1);
        check({tag, ".A2E"},   32'(A2E),       hist[2].a2);
        check({tag, ".A3E"},   32'(A3E),       hist[2].a3);
        check({tag, ".resE"},  32'(res_E),     hist[2].res);
        check({tag, ".A3M"},   32'(A3M),       hist[1].a3);
        check({tag, ".resM"},  32'(res_M),     hist[1].res);
        check({tag, ".A3W"},   32'(A3W),       hist[0].a3);
        check({tag, ".resW"},  32'(res_W),     hist[0].res);
        check({tag, ".cnt"},   32'(stall_cnt), ref_cnt);
    endtask

    // Called at posedge+1; returns at the following posedge+1
    task automatic cycle(input string tag, input logic [31:0] ins, input logic st, input logic fl);
        ent_t d;
        ent_t nxt;
        instr_d = ins;
        stall   = st;
        flush_d = fl;
        #1;
        d = ref_decode(ins);
        check({tag, ".A1D"},   32'(A1D),   d.a1);
        check({tag, ".A2D"},   32'(A2D),   d.a2);
        check({tag, ".en_pc"}, 32'(en_pc), st ? 0 : 1);
        check({tag, ".en_d"},  32'(en_d),  st ? 0 : 1);
        check({tag, ".clr_e"}, 32'(clr_e), st ? 1 : 0);
        nxt = (st || fl) ? bubble() : d;
        @(posedge clk);
        model_edge(nxt, st);
        #1;
        check_pipe(tag);
    endtask

    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_pipe(tag);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] rand_ins();
        int rs, rt, rd, sh;
        logic [31:0] ins;
        rs = $urandom_range(0, 31);
        rt = $urandom_range(0, 31);
        rd = $urandom_range(0, 31);
        sh = $urandom_range(0, 31);
        case ($urandom_range(0, 12))
            0:  ins = r_ins(rs, rt, rd, sh, 'h21);
            1:  ins = r_ins(rs, rt, rd, sh, 'h23);
            2:  ins = r_ins(rs, rt, rd, sh, 'h24);
            3:  ins = r_ins(rs, 0, 0, 0, 'h08);
            4:  ins = i_ins('h0d, rs, rt, $urandom);
            5:  ins = i_ins('h08, rs, rt, $urandom);
            6:  ins = i_ins('h0f, 0, rt, $urandom);
            7:  ins = i_ins('h23, rs, rt, $urandom);
            8:  ins = i_ins('h2b, rs, rt, $urandom);
            9:  ins = i_ins('h04, rs, rt, $urandom);
            10: ins = {6'b000010, 26'($urandom)};
            11: ins = {6'b000011, 26'($urandom)};
            default: ins = $urandom;
        endcase
        return ins;
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0000;

    initial begin
        rst_n   = 1'b0;
        instr_d = NOP;
        stall   = 1'b0;
        flush_d = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_pipe("reset");
        rst_n = 1'b1;

        // addu $3,$1,$2 for three cycles, then a NOP
        cycle("addu1", r_ins(1, 2, 3, 0, 'h21), 1'b0, 1'b0);
        check("addu1.A3E_lit", 32'(A3E), 3);
        check("addu1.resE_lit", 32'(res_E), 1);
        cycle("addu2", r_ins(1, 2, 3, 0, 'h21), 1'b0, 1'b0);
        check("addu2.A3M_lit", 32'(A3M), 3);
        cycle("addu3", r_ins(1, 2, 3, 0, 'h21), 1'b0, 1'b0);
        check("addu3.A3W_lit", 32'(A3W), 3);
        check("addu3.resW_lit", 32'(res_W), 1);
        cycle("nop", NOP, 1'b0, 1'b0);

        // lw $5,0($0) then a one-cycle load-use stall
        cycle("lw", i_ins('h23, 0, 5, 0), 1'b0, 1'b0);
        cycle("lwstall", r_ins(5, 1, 2, 0, 'h21), 1'b1, 1'b0);
        check("lwstall.A3M_lit", 32'(A3M), 5);
        check("lwstall.resM_lit", 32'(res_M), 2);
        check("lwstall.A3E_lit", 32'(A3E), 0);
        check("lwstall.resE_lit", 32'(res_E), 0);
        check("lwstall.cnt_lit", 32'(stall_cnt), 1);

        // jal then a flushed ori
        cycle("jal", {6'b000011, 26'h0000_100}, 1'b0, 1'b0);
        check("jal.resE_lit", 32'(res_E), 3);
        check("jal.A3E_lit", 32'(A3E), 31);
        cycle("oriflush", i_ins('h0d, 0, 4, 1), 1'b0, 1'b1);
        check("oriflush.A3E_lit", 32'(A3E), 0);
        check("oriflush.resE_lit", 32'(res_E), 0);

        // stall and flush together: stall wins, then addi proceeds
        instr_d = i_ins('h08, 0, 7, 5);
        stall   = 1'b1;
        flush_d = 1'b1;
        #1;
        check("both.en_d_lit", 32'(en_d), 0);
        cycle("both", i_ins('h08, 0, 7, 5), 1'b1, 1'b1);
        check("both.A3E_lit", 32'(A3E), 0);
        cycle("addi", i_ins('h08, 0, 7, 5), 1'b0, 1'b0);
        check("addi.A3E_lit", 32'(A3E), 7);
        check("addi.resE_lit", 32'(res_E), 1);

        // No-write cases
        cycle("sw", i_ins('h2b, 2, 6, 4), 1'b0, 1'b0);
        check("sw.resE_lit", 32'(res_E), 0);
        check("sw.A3E_lit", 32'(A3E), 0);
        cycle("addu0", r_ins(1, 2, 0, 0, 'h21), 1'b0, 1'b0);
        check("addu0.resE_lit", 32'(res_E), 0);
        check("addu0.A3E_lit", 32'(A3E), 0);

        // Reset mid-stream, then the first instruction reaches E after one edge
        cycle("prerst", i_ins('h23, 1, 9, 0), 1'b0, 1'b0);
        mid_reset("midrst");
        cycle("postrst", i_ins('h0d, 1, 10, 3), 1'b0, 1'b0);
        check("postrst.A3E_lit", 32'(A3E), 10);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle("rand", rand_ins(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 199) == 0) mid_reset("randrst");
        end

        // Long stall to saturate the counter
        instr_d = rand_ins();
        stall   = 1'b1;
        flush_d = 1'b0;
        repeat ((1 << CNT_W) + 5) begin
            @(posedge clk);
            model_edge(bubble(), 1'b1);
        end
        #1;
        check_pipe("sat");
        check("sat.cnt_lit", 32'(stall_cnt), CNT_MAX);
        cycle("satmore", rand_ins(), 1'b1, 1'b0);
        check("satmore.cnt_lit", 32'(stall_cnt), CNT_MAX);

        // Fill the pipe with writers, then reset mid-cycle
        stall = 1'b0;
        cycle("fill1", r_ins(1, 2, 3, 0, 'h21), 1'b0, 1'b0);
        cycle("fill2", i_ins('h23, 1, 4, 0), 1'b0, 1'b0);
        cycle("fill3", {6'b000011, 26'h1}, 1'b0, 1'b0);
        mid_reset("finalrst");
        check("finalrst.cnt_lit", 32'(stall_cnt), 0);
        check("finalrst.A3W_lit", 32'(A3W), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_info_pipe.md
HAZARD_INFO_PIPE -- requirements
Module: hazard_info_pipe

Interface
REQ-001 Parameter RES_W, default 2, width of the result-source code.
REQ-002 Parameter CNT_W, default 16, width of the stall-cycle counter.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 instr_d  input  32  instruction currently in the D stage.
REQ-006 stall  input  1  load-use stall request from the hazard detection unit.
REQ-007 flush_d  input  1  jump or branch redirect that squashes the instruction in D.
REQ-008 A1D, A2D  output  5 each  rs and rt fields of instr_d (combinational).
REQ-009 A1E, A2E, A3E  output  5 each  rs, rt and destination of the E-stage instruction.
REQ-010 A3M, A3W  output  5 each  destination register in the M and W stages.
REQ-011 res_E, res_M, res_W  output  RES_W each  result source per stage (00 NW, 01 ALU, 10 DM, 11 PC).
REQ-012 en_pc, en_d  output  1 each  PC and IF/ID register write enables.
REQ-013 clr_e  output  1  ID/EX bubble insert.
REQ-014 stall_cnt  output  CNT_W  number of stall cycles since reset.

Function
REQ-015 The decoder SHALL produce the destination and result code from opcode [31:26] and funct [5:0].
- op 000000 with funct addu, subu or and: A3 = rd, res ALU.
- op 000000 with funct jr: A3 = 0, res NW.
- ori, addi, lui: A3 = rt, res ALU.
- lw: A3 = rt, res DM.
- jal: A3 = 31, res PC.
- beq, j, sw and any unrecognised op: A3 = 0, res NW.
REQ-016 Whenever the decoded A3 is 0, res SHALL be forced to NW.
REQ-017 With stall=0 and flush_d=0, each edge SHALL shift {A1,A2,A3,res} D to E, and {A3,res} E to M and M to W.
- Latency from D to W is 3 cycles.
REQ-018 With stall=1, the E stage SHALL load a bubble (A1E=A2E=A3E=0, res_E=NW) while M and W still advance.
REQ-019 During stall: en_pc=0, en_d=0, clr_e=1; otherwise en_pc=1, en_d=1, clr_e=0.
- These three outputs are combinational from stall.
REQ-020 With flush_d=1 and stall=0, the D-stage decode SHALL be replaced by a bubble when loaded into E.
REQ-021 stall and flush_d asserted together: stall SHALL take priority.
- Bubble into E, en_d=0; flush_d is ignored that cycle.
REQ-022 stall_cnt SHALL increment on each edge with stall=1 and saturate at all-ones.
REQ-023 A stall asserted for N consecutive cycles SHALL insert exactly N bubbles and hold D for N cycles.

Reset
REQ-024 rst_n low SHALL asynchronously clear these outputs:
- A1E, A2E, A3E, A3M, A3W = 0
- res_E, res_M, res_W = NW
- stall_cnt = 0
REQ-025 Reset asserted mid-stream SHALL discard all in-flight stage state.
- The first instruction after release reaches E one edge later.

Structure
REQ-026 The result codes (NW, ALU, DM, PC) and the opcode/funct constants SHALL live in the shared pipeline definitions package, shared with the hazard detection unit.
REQ-027 Decoding SHALL be a combinational sub-module hazard_info_decode (instr in; A1, A2, A3, res out).
REQ-028 The stage registers SHALL be kept in hazard_info_pipe.

Verification
REQ-029 Reset then instr_d=addu $3,$1,$2 for 3 cycles, with the next instruction a NOP.
- Required: A3E=3/res_E=01 after edge 1, A3M=3 after edge 2, A3W=3/res_W=01 after edge 3.
REQ-030 lw $5,0($0), then stall=1 for 1 cycle.
- Required: A3M=5/res_M=10, A3E=0/res_E=00, en_pc=0, en_d=0, clr_e=1, stall_cnt=1.
REQ-031 jal in D, then flush_d=1 with ori $4 in D.
- Required: res_E=11/A3E=31, then next edge A3E=0/res_E=00.
REQ-032 stall=1 and flush_d=1 together with addi $7 in D.
- Required: bubble in E, en_d=0.
- Then stall=0: A3E=7/res_E=01.
REQ-033 sw $6,4($2) and addu $0,$1,$2.
- Required: res_E=00 and A3E=0 for both.
REQ-034 Hold stall=1 for 2^CNT_W+5 cycles: stall_cnt saturates at all-ones.
- Then assert rst_n=0 mid-cycle: all outputs per REQ-024 before the next edge.
